// File: rtl/apb_mem_slave.sv
// Parametrised APB3/APB4 memory slave: word-addressed register array with byte strobes,
// optional wait states and an error response for out-of-range addresses.
module apb_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic                  pready,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pslverr
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } stateType;

    stateType state, nextState;

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addrQ;
    logic              writeQ;
    logic [DATA_W-1:0] wdataQ;
    logic [LANES-1:0]  strbQ;
    logic              errQ;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic              inRange;
    logic              commit;
    logic [IDX_W-1:0]  setupIdx;
    logic [IDX_W-1:0]  accessIdx;

    // Range check is one bit wider than paddr so DEPTH == 2**ADDR_W never flags an error.
    assign inRange   = {1'b0, paddr} < (ADDR_W+1)'(DEPTH);
    assign setupIdx  = paddr[IDX_W-1:0];
    assign accessIdx = addrQ[IDX_W-1:0];

    assign setup   = (state == IDLE) && psel && !penable;
    assign pready  = (state == ACCESS) && psel && penable && (cnt == 4'd0);
    assign pslverr = pready && errQ;
    assign commit  = pready && writeQ && !errQ;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Dropping psel in ACCESS aborts the transfer without touching memory.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || pready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Read data is fetched at the setup edge so it is stable for the whole access phase.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt    <= '0;
            addrQ  <= '0;
            writeQ <= 1'b0;
            wdataQ <= '0;
            strbQ  <= '0;
            errQ   <= 1'b0;
            prdata <= '0;
        end else if (setup) begin
            cnt    <= 4'(WAIT_STATES);
            addrQ  <= paddr;
            writeQ <= pwrite;
            wdataQ <= pwdata;
            strbQ  <= pstrb;
            errQ   <= !inRange;
            if (!pwrite) begin
                prdata <= inRange ? mem[setupIdx] : '0;
            end
        end else if ((state == ACCESS) && psel && penable && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int l = 0; l < LANES; l++) begin
                if (strbQ[l]) begin
                    mem[accessIdx][8*l +: 8] <= wdataQ[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (zero and three wait states) driven with directed
// and random APB transfers, checked against an array-based memory model.
module tb_apb_mem_slave;

    localparam int DEPTH = 64;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    logic                  pclk;
    logic                  preset;
    logic [1:0]            psel;
    logic [1:0]            penable;
    logic [1:0]            pwrite;
    logic [1:0][7:0]       paddr;
    logic [1:0][31:0]      pwdata;
    logic [1:0][3:0]       pstrb;
    wire  [1:0]            pready;
    wire  [1:0][31:0]      prdata;
    wire  [1:0]            pslverr;

    logic [31:0] model [2][DEPTH];
    logic [31:0] lastRead [2];
    int          assertCount;
    int          failCount;

    apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            lastRead[d] = '0;
            for (int a = 0; a < DEPTH; a++) model[d][a] = '0;
        end
    endtask

    // One full APB transfer on instance d, starting and ending just after a falling edge.
    task automatic applyStimulus(input int d, input bit wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output logic [31:0] rdata, output logic err, output int waits);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        pstrb[d]   = strb;
        @(posedge pclk);
        @(negedge pclk);
        penable[d] = 1'b1;
        #1;
        waits = 0;
        while (!pready[d] && waits < 40) begin
            @(posedge pclk);
            @(negedge pclk);
            #1;
            waits++;
        end
        checkOutput($sformatf("d%0d_pready_seen", d), {31'b0, pready[d]}, 32'd1);
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge pclk);
        @(negedge pclk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic modelTransfer(input int d, input bit wr, input int addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output logic [31:0] obsData);
        logic        err;
        int          waits;
        logic [31:0] mask;
        logic [31:0] expRd;
        applyStimulus(d, wr, 8'(addr), data, strb, obsData, err, waits);
        checkOutput($sformatf("d%0d_waits_a%0d", d, addr), 32'(waits), 32'((d == 0) ? WS0 : WS1));
        checkOutput($sformatf("d%0d_pslverr_a%0d", d, addr), {31'b0, err}, {31'b0, addr >= DEPTH});
        if (!wr) begin
            expRd = (addr < DEPTH) ? model[d][addr] : 32'h0;
            lastRead[d] = expRd;
            checkOutput($sformatf("d%0d_rdata_a%0d", d, addr), obsData, expRd);
        end else begin
            checkOutput($sformatf("d%0d_rdhold_a%0d", d, addr), obsData, lastRead[d]);
            if (addr < DEPTH) begin
                mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
                model[d][addr] = (model[d][addr] & ~mask) | (data & mask);
            end
        end
    endtask

    task automatic checkIdle(input int d);
        #1;
        checkOutput($sformatf("d%0d_idle_pready", d), {31'b0, pready[d]}, 32'd0);
        checkOutput($sformatf("d%0d_idle_pslverr", d), {31'b0, pslverr[d]}, 32'd0);
        checkOutput($sformatf("d%0d_idle_prdata", d), prdata[d], lastRead[d]);
    endtask

    task automatic applyReset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        clearModel();
    endtask

    logic [31:0] rd;

    initial begin
        assertCount = 0;
        failCount   = 0;
        preset      = 1'b1;
        psel        = '0;
        penable     = '0;
        pwrite      = '0;
        paddr       = '0;
        pwdata      = '0;
        pstrb       = '0;
        clearModel();
        @(negedge pclk);
        applyReset();

        checkIdle(0);
        checkIdle(1);

        // Reads straight after reset return zero with no error.
        modelTransfer(0, 1'b0, 0, 32'h0, 4'h0, rd);
        checkOutput("rst_read0", rd, 32'h0);
        modelTransfer(0, 1'b0, DEPTH-1, 32'h0, 4'h0, rd);
        checkOutput("rst_read63", rd, 32'h0);

        modelTransfer(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, rd);
        modelTransfer(0, 1'b1, 5, 32'h11223344, 4'b0101, rd);
        modelTransfer(0, 1'b0, 5, 32'h0, 4'h0, rd);
        checkOutput("strb_merge", rd, 32'hDE22BE44);

        modelTransfer(1, 1'b1, 10, 32'hA5A5A5A5, 4'hF, rd);
        modelTransfer(1, 1'b0, 10, 32'h0, 4'h0, rd);
        checkOutput("ws3_readback", rd, 32'hA5A5A5A5);

        modelTransfer(0, 1'b1, 64, 32'hFFFFFFFF, 4'hF, rd);
        modelTransfer(0, 1'b0, 200, 32'h0, 4'h0, rd);
        checkOutput("oor_read", rd, 32'h0);
        modelTransfer(0, 1'b0, 0, 32'h0, 4'h0, rd);
        modelTransfer(0, 1'b0, 5, 32'h0, 4'h0, rd);
        checkOutput("oor_nochange", rd, 32'hDE22BE44);

        // Back-to-back: the read setup follows the write completion directly.
        modelTransfer(0, 1'b1, 3, 32'h12345678, 4'hF, rd);
        modelTransfer(0, 1'b0, 3, 32'h0, 4'h0, rd);
        checkOutput("b2b_raw", rd, 32'h12345678);
        checkIdle(0);

        // Reset during the second wait cycle of a write on the wait-state instance.
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = 8'd7;
        pwdata[1]  = 32'h77777777;
        pstrb[1]   = 4'hF;
        @(posedge pclk);
        @(negedge pclk);
        penable[1] = 1'b1;
        #1;
        checkOutput("midrst_wait1", {31'b0, pready[1]}, 32'd0);
        @(posedge pclk);
        @(negedge pclk);
        preset = 1'b1;
        #1;
        checkOutput("midrst_pready", {31'b0, pready[1]}, 32'd0);
        checkOutput("midrst_prdata", prdata[1], 32'h0);
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        clearModel();
        modelTransfer(1, 1'b0, 7, 32'h0, 4'h0, rd);
        checkOutput("midrst_mem7", rd, 32'h0);
        modelTransfer(1, 1'b1, 7, 32'hCAFEF00D, 4'hF, rd);
        modelTransfer(1, 1'b0, 7, 32'h0, 4'h0, rd);
        checkOutput("midrst_next", rd, 32'hCAFEF00D);
        modelTransfer(0, 1'b0, 5, 32'h0, 4'h0, rd);
        checkOutput("midrst_mem5", rd, 32'h0);

        // Random traffic, addresses slightly past DEPTH to exercise the error path.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                modelTransfer(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH + 15)),
                              $urandom, 4'($urandom), rd);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge pclk);
                    @(negedge pclk);
                    checkIdle(d);
                end
            end
            for (int a = 0; a < DEPTH; a++) begin
                modelTransfer(d, 1'b0, a, 32'h0, 4'h0, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
